// File: rtl/mem_op_sequencer_pkg.sv
// Shared encodings for the calculator sequencer: button codes, FSM states,
// display-mux selects and operand/memory source selects.
package mem_op_sequencer_pkg;

  localparam logic [4:0] BTN_ENTER  = 5'b10001;
  localparam logic [4:0] BTN_RECALL = 5'b10010;
  localparam logic [4:0] BTN_STORE  = 5'b10100;
  localparam logic [4:0] BTN_CLEAR  = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_EXEC   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ENTER,
    CMD_RECALL,
    CMD_STORE,
    CMD_CLEAR
  } cmd_e;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_R   = 2'd2;
  localparam logic [1:0] DISP_MEM = 2'd3;

  localparam logic OP_SRC_SW  = 1'b0;
  localparam logic OP_SRC_MEM = 1'b1;
  localparam logic M_SRC_SW   = 1'b0;
  localparam logic M_SRC_RES  = 1'b1;

  // Anything other than an exact strobed code is a no-op.
  function automatic cmd_e decode_btn(input logic [4:0] btn);
    cmd_e c;
    case (btn)
      BTN_ENTER:  c = CMD_ENTER;
      BTN_RECALL: c = CMD_RECALL;
      BTN_STORE:  c = CMD_STORE;
      BTN_CLEAR:  c = CMD_CLEAR;
      default:    c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_op_sequencer_cycle_timer.sv
// EXEC watchdog: counts up from 0 while enabled, saturates at TIMEOUT_CYCLES.
module cycle_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW             = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_op_sequencer.sv
// Calculator sequencer: decodes button presses, sequences operand capture,
// ALU start/timeout, result latch and memory write arbitration.
//
// state    | meaning
// S_IDLE   | waiting for first operand (A)
// S_HAVE_A | A captured, waiting for second operand (B)
// S_EXEC   | ALU running, watchdog active
// S_RESULT | result latched, may store or chain
module mem_op_sequencer
  import mem_op_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW             = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] buttonPulse,
  input  logic       alu_done,
  output logic       ld_a,
  output logic       ld_b,
  output logic       op_src,
  output logic       alu_start,
  output logic       ld_r,
  output logic       st_m,
  output logic       m_src,
  output logic       clr,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  cmd_e       cmd;
  logic       expired;
  logic       ld_a_q, ld_a_d, ld_b_q, ld_b_d, op_src_q, op_src_d;
  logic       alu_start_q, alu_start_d, ld_r_q, ld_r_d;
  logic       st_m_q, st_m_d, m_src_q, m_src_d, clr_q, clr_d;
  logic       busy_q, busy_d, err_q, err_d;
  logic [1:0] disp_sel_q, disp_sel_d;

  assign cmd = decode_btn(buttonPulse);

  cycle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != S_EXEC),
    .en     (state_q == S_EXEC),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      op_src_q    <= 1'b0;
      alu_start_q <= 1'b0;
      ld_r_q      <= 1'b0;
      st_m_q      <= 1'b0;
      m_src_q     <= 1'b0;
      clr_q       <= 1'b0;
      disp_sel_q  <= DISP_A;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_a_q      <= ld_a_d;
      ld_b_q      <= ld_b_d;
      op_src_q    <= op_src_d;
      alu_start_q <= alu_start_d;
      ld_r_q      <= ld_r_d;
      st_m_q      <= st_m_d;
      m_src_q     <= m_src_d;
      clr_q       <= clr_d;
      disp_sel_q  <= disp_sel_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd == CMD_CLEAR) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_RESULT: begin
          if (cmd == CMD_ENTER || cmd == CMD_RECALL) state_d = S_HAVE_A;
        end
        S_HAVE_A: begin
          if (cmd == CMD_ENTER || cmd == CMD_RECALL) state_d = S_EXEC;
        end
        S_EXEC: begin
          if (alu_done)     state_d = S_RESULT;
          else if (expired) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_a_d      = 1'b0;
    ld_b_d      = 1'b0;
    op_src_d    = OP_SRC_SW;
    ld_r_d      = 1'b0;
    st_m_d      = 1'b0;
    m_src_d     = M_SRC_SW;
    clr_d       = 1'b0;
    disp_sel_d  = disp_sel_q;
    err_d       = err_q;
    busy_d      = (state_d == S_EXEC);
    // ALU starts the cycle after ld_b, unless that cycle aborts EXEC.
    alu_start_d = ld_b_q && (state_d == S_EXEC);
    if (cmd == CMD_CLEAR) begin
      clr_d      = 1'b1;
      err_d      = 1'b0;
      disp_sel_d = DISP_A;
    end else begin
      unique case (state_q)
        S_IDLE, S_RESULT: begin
          if (cmd == CMD_ENTER) begin
            ld_a_d     = 1'b1;
            disp_sel_d = DISP_A;
          end else if (cmd == CMD_RECALL) begin
            ld_a_d     = 1'b1;
            op_src_d   = OP_SRC_MEM;
            disp_sel_d = DISP_MEM;
          end else if (cmd == CMD_STORE) begin
            st_m_d  = 1'b1;
            m_src_d = (state_q == S_RESULT) ? M_SRC_RES : M_SRC_SW;
          end
        end
        S_HAVE_A: begin
          if (cmd == CMD_ENTER || cmd == CMD_RECALL) begin
            ld_b_d     = 1'b1;
            op_src_d   = (cmd == CMD_RECALL) ? OP_SRC_MEM : OP_SRC_SW;
            disp_sel_d = DISP_B;
          end else if (cmd == CMD_STORE) begin
            st_m_d = 1'b1;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            ld_r_d     = 1'b1;
            disp_sel_d = DISP_R;
          end else if (expired) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_a      = ld_a_q;
  assign ld_b      = ld_b_q;
  assign op_src    = op_src_q;
  assign alu_start = alu_start_q;
  assign ld_r      = ld_r_q;
  assign st_m      = st_m_q;
  assign m_src     = m_src_q;
  assign clr       = clr_q;
  assign disp_sel  = disp_sel_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
